// File: rtl/neuron_mac_ctrl_if.sv
// neuron_mac_ctrl_if: start/ROM-read/accumulator/result bundle for the neuron MAC controller.
interface neuron_mac_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 5
);
    logic                  start;
    logic [ADDR_W-1:0]     n_inputs;
    logic                  rd_en;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     x;
    logic [DATA_W-1:0]     w;
    logic                  acc_rst;
    logic                  acc_ce;
    logic [2*DATA_W-1:0]   A;
    logic [27:0]           Y;
    logic                  busy;
    logic                  done;
    logic [27:0]           result;

    modport master (
        input  start, n_inputs, x, w, Y,
        output rd_en, addr, acc_rst, acc_ce, A, busy, done, result
    );
    modport slave (
        output start, n_inputs, x, w, Y,
        input  rd_en, addr, acc_rst, acc_ce, A, busy, done, result
    );
endinterface

// File: rtl/neuron_mac_ctrl.sv
// neuron_mac_ctrl: sequences synapse reads, feeds x*w products to an external accumulator, captures the sum.
module neuron_mac_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    neuron_mac_ctrl_if.master    bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, CAPTURE, DONE} state_t;

    state_t                     state_q;
    logic [ADDR_W-1:0]          n_q, addr_q;
    logic                       rd_en_q, vld_q, acc_rst_q, acc_ce_q, busy_q, done_q;
    logic signed [2*DATA_W-1:0] a_q, a_d, x_ext, w_ext;
    logic [27:0]                result_q;

    assign x_ext = {{DATA_W{bus.x[DATA_W-1]}}, bus.x};
    assign w_ext = {{DATA_W{bus.w[DATA_W-1]}}, bus.w};
    assign a_d   = x_ext * w_ext;

    // vld_q marks the cycle in which ROM data for an earlier rd_en is present on x/w
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            vld_q     <= 1'b0;
            acc_rst_q <= 1'b0;
            acc_ce_q  <= 1'b0;
            a_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            vld_q     <= rd_en_q;
            acc_ce_q  <= vld_q;
            acc_rst_q <= 1'b0;
            done_q    <= 1'b0;
            if (vld_q) a_q <= a_d;
            case (state_q)
                IDLE: if (bus.start) begin
                    busy_q   <= 1'b1;
                    result_q <= '0;
                    n_q      <= bus.n_inputs;
                    addr_q   <= '0;
                    if (bus.n_inputs == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        acc_rst_q <= 1'b1;
                        rd_en_q   <= 1'b1;
                        state_q   <= CLEAR;
                    end
                end
                CLEAR, RUN: if (addr_q == n_q - ADDR_W'(1)) begin
                    rd_en_q <= 1'b0;
                    state_q <= DRAIN;
                end else begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    state_q <= RUN;
                end
                DRAIN: if (acc_ce_q && !vld_q) state_q <= CAPTURE;
                CAPTURE: begin
                    result_q <= bus.Y;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.addr    = addr_q;
    assign bus.acc_rst = acc_rst_q;
    assign bus.acc_ce  = acc_ce_q;
    assign bus.A       = a_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// tb_neuron_mac_ctrl: random and directed neuron evaluations against a sum-of-products reference.
module tb_neuron_mac_ctrl;
    localparam int AW = 8;
    localparam int DW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   xv[256];
    int   wv[256];

    always #5 clk = ~clk;

    neuron_mac_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    neuron_mac_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    // synchronous synapse ROM and downstream accumulator
    always @(posedge clk) if (bus.rd_en) begin
        bus.x <= xv[bus.addr][DW-1:0];
        bus.w <= wv[bus.addr][DW-1:0];
    end

    always @(posedge clk or posedge rst)
        if (rst) bus.Y <= '0;
        else if (bus.acc_rst) bus.Y <= '0;
        else if (bus.acc_ce) bus.Y <= bus.Y + {{18{bus.A[2*DW-1]}}, bus.A};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(bus.rd_en), 0);
        chk({tag, "_addr"}, 32'(bus.addr), 0);
        chk({tag, "_acc_rst"}, 32'(bus.acc_rst), 0);
        chk({tag, "_acc_ce"}, 32'(bus.acc_ce), 0);
        chk({tag, "_A"}, 32'(bus.A), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_result"}, 32'(bus.result), 0);
    endtask

    task automatic run(input int n, input bit noise);
        int s, done_c, ce_n, ce_first, ce_last, rd_n, rs_n, rs_c, busy_bad, amax;
        s = 0;
        for (int i = 0; i < n; i++) s += xv[i] * wv[i];
        @(negedge clk);
        bus.start = 1'b1;
        bus.n_inputs = AW'(n);
        @(negedge clk);
        done_c = -1; ce_n = 0; ce_first = -1; ce_last = -1;
        rd_n = 0; rs_n = 0; rs_c = -1; busy_bad = 0; amax = 0;
        for (int c = 0; c < n + 10; c++) begin
            if (!bus.busy) busy_bad++;
            if (bus.rd_en) begin
                rd_n++;
                if (int'(bus.addr) > amax) amax = int'(bus.addr);
            end
            if (bus.acc_rst) begin rs_n++; rs_c = c; end
            if (bus.acc_ce) begin
                if (ce_first < 0) ce_first = c;
                ce_last = c;
                if (ce_n < n) chk("A", 32'(bus.A), (xv[ce_n] * wv[ce_n]) & 32'h3FF);
                ce_n++;
            end
            if (bus.done) begin done_c = c; break; end
            bus.start = noise ? 1'($urandom) : 1'b0;
            bus.n_inputs = AW'($urandom);
            @(negedge clk);
        end
        chk("done_cycle", done_c, n == 0 ? 0 : n + 3);
        chk("result", 32'(bus.result), s & 32'hFFFFFFF);
        chk("ce_count", ce_n, n);
        chk("ce_first", ce_first, n == 0 ? -1 : 2);
        chk("ce_last", ce_last, n == 0 ? -1 : n + 1);
        chk("rd_count", rd_n, n);
        chk("addr_max", amax, n == 0 ? 0 : n - 1);
        chk("accrst_count", rs_n, n == 0 ? 0 : 1);
        chk("accrst_cycle", rs_c, n == 0 ? -1 : 0);
        chk("busy_span", busy_bad, 0);
        bus.start = noise;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after", 32'(bus.busy), 0);
        chk("done_after", 32'(bus.done), 0);
        chk("result_hold", 32'(bus.result), s & 32'hFFFFFFF);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.n_inputs = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        xv[0:3] = '{1, 2, 3, 4};
        wv[0:3] = '{1, 1, 1, 1};
        run(4, 0);
        xv[0] = -16; wv[0] = -16;
        run(1, 0);
        xv[0:2] = '{-16, 5, 0};
        wv[0:2] = '{15, -3, 7};
        run(3, 0);
        run(0, 1);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 256; i++) begin
                xv[i] = int'($urandom_range(31)) - 16;
                wv[i] = int'($urandom_range(31)) - 16;
            end
            run(int'($urandom_range(24, 1)), 1'(r & 1));
        end

        for (int i = 0; i < 256; i++) begin xv[i] = -16; wv[i] = -16; end
        run(255, 1);

        @(negedge clk);
        bus.start = 1'b1;
        bus.n_inputs = 8'd255;
        @(negedge clk);
        for (int c = 0; c < 100; c++) begin
            bus.start = 1'($urandom);
            bus.n_inputs = AW'($urandom);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1 chk_zero("abort");
        bus.start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_done", 32'(bus.done), 0);
        end
        rst = 1'b0;
        xv[0:1] = '{7, -9};
        wv[0:1] = '{-5, 11};
        run(2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/neuron_mac_ctrl.md
NEURON_MAC_CTRL -- requirements
Module: neuron_mac_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: width of the synapse address and of n_inputs.
REQ-002 Parameter DATA_W, default 5: width of the signed input sample x and the signed weight w; product width is 2*DATA_W (10).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to evaluate one neuron; sampled only in IDLE.
REQ-006 n_inputs  input  ADDR_W  number of synapses; sampled with start.
REQ-007 rd_en, addr  output  1, ADDR_W  synchronous ROM/RAM read request and address; data returns exactly one cycle later.
REQ-008 x, w  input  DATA_W each  two's-complement sample and weight for the address issued one cycle earlier.
REQ-009 acc_rst, acc_ce  output  1 each  clear and enable to the downstream accumulator.
REQ-010 A  output  2*DATA_W  registered two's-complement product x*w, to accumulator input.
REQ-011 Y  input  28  accumulator running sum; valid one cycle after each acc_ce or acc_rst.
REQ-012 busy, done, result  output  1, 1, 28  busy high from C0 through the done cycle; done is a one-cycle pulse; result holds the final sum.

Function
REQ-013 FSM states: IDLE, CLEAR, RUN, DRAIN, CAPTURE, DONE.
REQ-014 IDLE with start=1 and n_inputs!=0 -> CLEAR. With n_inputs=0 -> DONE, result=0, no rd_en/acc_ce/acc_rst pulses.
REQ-015 Cycle numbering: C0 is the first cycle after start is accepted.
REQ-016 CLEAR (C0): acc_rst=1, rd_en=1, addr=0.
REQ-017 RUN (C1..Cn-1): rd_en=1, addr=k in Ck; after addr=n-1 is issued -> DRAIN.
REQ-018 Product pipeline: x,w for address k are sampled in C(k+1); A = x*w (signed, full 2*DATA_W, no truncation) is registered and driven with acc_ce=1 in C(k+2).
REQ-019 acc_ce is high exactly n cycles (C2..C(n+1)), contiguous; A holds its last value when acc_ce=0.
REQ-020 DRAIN: rd_en=0; wait until the last acc_ce (C(n+1)) -> CAPTURE.
REQ-021 CAPTURE (C(n+2)): result <= Y -> DONE.
REQ-022 DONE (C(n+3)): done=1 for one cycle -> IDLE; result holds until the next accepted start.
REQ-023 Special case n=1: C0 CLEAR issues addr 0, RUN is skipped, acc_ce in C2, done in C4.
REQ-024 start while busy is ignored; n_inputs changes after acceptance have no effect.
REQ-025 start in the DONE cycle is ignored; start is accepted on the first IDLE cycle.
REQ-026 addr never exceeds n-1; n=2**ADDR_W-1 (255) is the maximum and requires no wrap.
REQ-027 -16*-16 = +256 and -16*15 = -240 fit in 10-bit signed form; no saturation.

Reset
REQ-028 rst=1 forces IDLE immediately, independent of clk.
REQ-029 rst=1 forces the outputs to: rd_en=0, addr=0, acc_rst=0, acc_ce=0, A=0, busy=0, done=0, result=0.
REQ-030 rst during any busy state aborts the evaluation; no done pulse is produced.
REQ-031 The first start after rst deassertion is accepted normally.

Verification
REQ-032 n=4; x={1,2,3,4}, w={1,1,1,1}; accumulator model attached -> acc_ce is high C2..C5, A=1,2,3,4, done in C7, result=10.
REQ-033 n=1, x=-16, w=-16 -> A=0x100, done in C4, result=256.
REQ-034 n=3, x={-16,5,0}, w={15,-3,7} -> A=0x310 (-240), 0x3F1 (-15), 0 -> result=-255 (0xFFFFF01).
REQ-035 n=0 with start=1 -> done in C0 with result=0; no acc_ce, acc_rst, or rd_en.
REQ-036 Start with n=255, then start pulses during busy, then rst asserted asynchronously in C100 -> all outputs zero at once, no done pulse; a new start with n=2 completes with done in C5.
